seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
- Time-multiplexing controller for the 4-digit seven-segment display. Drives the display decoder's `number[3:0]` and `anode_selector[1:0]` inputs.
- Scans digits 0..3 at a programmable refresh rate.
- Inserts a blanking interval at each digit switch to suppress ghosting.
- Double-buffers the displayed value so updates only take effect at frame boundaries (no tearing).
- Optional leading-zero suppression. Sits between application logic and the display decoder.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range 3..2^20.
- BLANK_DIV, 1000, cycles at the start of each slot during which the digit is blanked; legal range 1..REFRESH_DIV-2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  16  four BCD digits; [3:0] = digit 0 (least significant) .. [15:12] = digit 3.
- load  input  1  single-cycle strobe: capture `value` into the shadow register.
- lz_en  input  1  1 = suppress leading zeros.
- number  output  4  nibble to the decoder; 4'hF = blank.
- anode_selector  output  2  digit index to the decoder.
- frame_done  output  1  one-cycle pulse when digit 3's slot ends.
- busy  output  1  1 while a loaded value is pending transfer to the active register.

Behaviour:
- Reset (rst=1 at a clock edge): slot counter=0, idx=0, state=BLANK, number=4'hF, anode_selector=0, frame_done=0, busy=0, shadow=16'h0, active=16'h0. Reset takes priority over all other inputs, including mid-slot and mid-pending.
- All outputs are registered. `anode_selector` always equals idx.
- State machine, two states:
  - BLANK: number=4'hF while counter < BLANK_DIV; at counter==BLANK_DIV-1 go to SHOW.
  - SHOW: number=display nibble for idx; at counter==REFRESH_DIV-1 go to BLANK.
- Slot counter: counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0, idx increments mod 4 (3->0), and state goes to BLANK.
- Slot timing: each slot is exactly REFRESH_DIV cycles, of which BLANK_DIV cycles are blank. A full frame is 4*REFRESH_DIV cycles.
- Frame boundary (idx 3->0 wrap):
  - frame_done=1 for exactly that one cycle.
  - If busy=1: active<=shadow and busy<=0.
- load=1 (not at a frame boundary): shadow<=value, busy<=1. A repeated load before the boundary overwrites the shadow; the last load wins.
- load=1 coincident with a frame boundary: active<=value directly (bypass), shadow<=value, busy=0.
- Display nibble is computed from the active register only, never directly from `value`.
  - lz_en=0: nibble = active digit[idx].
  - lz_en=1: digit k (k=3..1) is blanked (4'hF) if it and all more significant digits are 0. Digit 0 is never suppressed (value 0 shows "0").
  - Non-BCD nibbles (A..E) pass through unchanged; the decoder blanks them.
  - A digit nibble of F is indistinguishable from blank; this is acceptable.
- Changing lz_en takes effect on the next number update; it is not synchronised to the frame.
- number changes on the same edge that the state/idx change it depends on. The decoder adds one further register stage, so total latency to the pins is 1 cycle after number.

Test Plan (REFRESH_DIV=8, BLANK_DIV=2):
- Reset release, value never loaded, lz_en=0 -> anode_selector sequence 0,1,2,3,0 at 8-cycle spacing; per slot number=F,F,0,0,0,0,0,0; frame_done pulses every 32 cycles.
- Load 16'h1234 mid-frame (idx=1) -> busy=1 and the display stays 0000 until the next frame_done; afterwards idx0..3 show 4,3,2,1; busy=0.
- Two loads (16'h1111, then 16'h5678) within one frame -> the next frame shows 8,7,6,5; 1111 never appears.
- Load 16'h9999 on the exact frame-boundary cycle -> the frame immediately following shows 9999; busy stays 0.
- lz_en=1, active=16'h0070 -> idx3=F, idx2=F, idx1=7, idx0=0. active=16'h0000 -> F,F,F,0.
- Assert rst mid-SHOW at idx=2 with busy=1 -> next cycle idx=0, number=F, busy=0, active=0000; scanning restarts from counter 0.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Four-digit seven-segment scanner with blanking, frame-synchronous
// double buffering and optional leading-zero suppression.
module seven_segment_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_DIV   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_en,
  output logic [3:0]  number,
  output logic [1:0]  anode_selector,
  output logic        frame_done,
  output logic        busy
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_n;
  logic [15:0] r_shadow;
  logic [15:0] r_active;
  logic [15:0] w_shadow_n;
  logic [15:0] w_active_n;
  logic        r_busy;
  logic        w_busy_n;
  logic        r_frame_done;
  logic [3:0]  r_number;
  logic [3:0]  w_number_n;
  logic [3:0]  w_digit;
  logic        w_lead;
  logic        w_slot_end;
  logic        w_blank_end;
  logic        w_frame_end;
  logic        w_nz3;
  logic        w_nz2;
  logic        w_nz1;

  assign w_slot_end  = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_blank_end = (r_cnt == CW'(BLANK_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_BLANK: if (w_blank_end) w_state_n = ST_SHOW;
      ST_SHOW:  if (w_slot_end)  w_state_n = ST_BLANK;
      default:  w_state_n = ST_BLANK;
    endcase
  end

  always_comb begin
    w_cnt_n = w_slot_end ? '0 : r_cnt + 1'b1;
    w_idx_n = w_slot_end ? r_idx + 2'd1 : r_idx;
  end

  // A load on the boundary edge bypasses the shadow straight to active.
  always_comb begin
    w_shadow_n = load ? value : r_shadow;
    w_active_n = r_active;
    w_busy_n   = r_busy;
    if (w_frame_end) begin
      if (load)        w_active_n = value;
      else if (r_busy) w_active_n = r_shadow;
      w_busy_n = 1'b0;
    end else if (load) begin
      w_busy_n = 1'b1;
    end
  end

  assign w_nz3 = |w_active_n[15:12];
  assign w_nz2 = w_nz3 | (|w_active_n[11:8]);
  assign w_nz1 = w_nz2 | (|w_active_n[7:4]);

  always_comb begin
    w_digit = w_active_n[3:0];
    w_lead  = 1'b0;
    unique case (w_idx_n)
      2'd0: begin
        w_digit = w_active_n[3:0];
        w_lead  = 1'b0;
      end
      2'd1: begin
        w_digit = w_active_n[7:4];
        w_lead  = !w_nz1;
      end
      2'd2: begin
        w_digit = w_active_n[11:8];
        w_lead  = !w_nz2;
      end
      2'd3: begin
        w_digit = w_active_n[15:12];
        w_lead  = !w_nz3;
      end
      default: begin
        w_digit = 4'hF;
        w_lead  = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_number_n = 4'hF;
    if (w_state_n == ST_SHOW && !(lz_en && w_lead)) begin
      w_number_n = w_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_shadow     <= 16'h0;
      r_active     <= 16'h0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_number     <= 4'hF;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_idx        <= w_idx_n;
      r_shadow     <= w_shadow_n;
      r_active     <= w_active_n;
      r_busy       <= w_busy_n;
      r_frame_done <= w_frame_end;
      r_number     <= w_number_n;
    end
  end

  assign number         = r_number;
  assign anode_selector = r_idx;
  assign frame_done     = r_frame_done;
  assign busy           = r_busy;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: directed scenarios plus random
// loads, all checked cycle by cycle against a timeline model.
module tb_seven_segment_scanner;

  localparam int R = 8;
  localparam int B = 2;
  localparam int F = 4 * R;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  number;
  logic [1:0]  anode_selector;
  logic        frame_done;
  logic        busy;

  int          tests = 0;
  int          fails = 0;
  int          t = 0;
  logic [15:0] m_act = 16'h0;
  logic [15:0] m_sh = 16'h0;
  logic        m_busy = 1'b0;
  logic        cur_lz = 1'b0;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .REFRESH_DIV(R),
    .BLANK_DIV(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .load(load),
    .lz_en(lz_en),
    .number(number),
    .anode_selector(anode_selector),
    .frame_done(frame_done),
    .busy(busy)
  );

  function automatic logic [3:0] exp_nib(
    input logic [15:0] act,
    input int k,
    input logic lz
  );
    int top;
    logic [3:0] d;
    d = act[4*k +: 4];
    if (!lz) return d;
    top = 0;
    for (int i = 0; i < 4; i++)
      if (act[4*i +: 4] != 4'h0) top = i;
    return (k > top) ? 4'hF : d;
  endfunction

  task automatic chk(
    input string tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d",
             tag, obs, exp, t);
    end
  endtask

  task automatic check_all(input logic rs, input logic lz);
    int slot;
    int idx;
    logic [3:0] en;
    slot = t % R;
    idx  = (t / R) % 4;
    if (rs || slot < B) en = 4'hF;
    else en = exp_nib(m_act, idx, lz);
    chk("number", {12'h0, number}, {12'h0, en});
    chk("anode", {14'h0, anode_selector}, 16'(idx));
    chk("frame_done", {15'h0, frame_done},
        {15'h0, (!rs && t > 0 && (t % F) == 0)});
    chk("busy", {15'h0, busy}, {15'h0, m_busy});
  endtask

  task automatic step(
    input logic ld,
    input logic [15:0] v,
    input logic rs
  );
    logic bnd;
    @(negedge clk);
    load  = ld;
    value = v;
    lz_en = cur_lz;
    rst   = rs;
    @(posedge clk);
    if (rs) begin
      t = 0;
      m_act = 16'h0;
      m_sh = 16'h0;
      m_busy = 1'b0;
    end else begin
      bnd = ((t % F) == F - 1);
      if (bnd) begin
        if (ld) m_act = v;
        else if (m_busy) m_act = m_sh;
        m_busy = 1'b0;
        if (ld) m_sh = v;
      end else if (ld) begin
        m_sh = v;
        m_busy = 1'b1;
      end
      t++;
    end
    #1 check_all(rs, cur_lz);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic seek(input int idx, input int slot);
    for (int i = 0; i < 2 * F; i++) begin
      if (((t / R) % 4) == idx && (t % R) == slot) break;
      step(1'b0, 16'h0, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] v;
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    idle(2 * F + 4);

    seek(1, 3);
    step(1'b1, 16'h1234, 1'b0);
    idle(2 * F);

    seek(0, 5);
    step(1'b1, 16'h1111, 1'b0);
    idle(5);
    step(1'b1, 16'h5678, 1'b0);
    idle(2 * F);

    seek(3, R - 1);
    step(1'b1, 16'h9999, 1'b0);
    idle(F + 3);

    cur_lz = 1'b1;
    step(1'b1, 16'h0070, 1'b0);
    idle(2 * F);
    step(1'b1, 16'h0000, 1'b0);
    idle(2 * F);
    step(1'b1, 16'h0305, 1'b0);
    idle(2 * F);

    seek(1, 4);
    step(1'b1, 16'h4321, 1'b0);
    seek(2, 4);
    step(1'b0, 16'h0, 1'b1);
    idle(F + 8);

    for (int i = 0; i < 3000; i++) begin
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v[15:12] = 4'h0;
        1: v[15:8] = 8'h0;
        2: v[15:4] = 12'h0;
        default: ;
      endcase
      if ($urandom_range(0, 63) == 0) cur_lz = ~cur_lz;
      step($urandom_range(0, 24) == 0, v,
           $urandom_range(0, 999) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
